// File: rtl/serial_slave_port.sv
// Slave endpoint of the bit-serial bus: deserialises address/write data, drives one
// memory strobe, serialises read data back. Optional RX stall timeout: SERIAL_SLAVE_PORT_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for first valid bit of a frame, slave_ready=1
// RX_ADDR   | shifting in address bits
// RX_DATA   | shifting in write-data bits
// WRITE     | one-cycle mem_we
// READ_WAIT | waiting READ_LATENCY cycles after mem_re
// TX_DATA   | shifting read data out while bus_ready=1
module serial_slave_port #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_DEPTH    = 4096,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_address,
  input  logic                  bus_data,
  input  logic                  bus_valid,
  input  logic                  bus_write_en,
  input  logic                  bus_ready,
  output logic                  slave_ready,
  output logic                  slave_data_out,
  output logic                  slave_valid_out,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  frame_error
);

  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LAT_W   = $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, RX_ADDR, RX_DATA, WRITE, READ_WAIT, TX_DATA} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  write_q, write_d;
  logic                  re_q, re_d;
  logic                  addr_done;
  logic                  abort;

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} >= (ADDR_WIDTH+1)'(MEM_DEPTH);
  endfunction

`ifdef SERIAL_SLAVE_PORT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] stall_q, stall_d;
  logic            rx_state;

  // Down-counter reloads on every valid bit; a stall seen at zero is the TIMEOUT-th one.
  always_comb begin
    rx_state = (state_q == RX_ADDR) || (state_q == RX_DATA);
    abort    = rx_state && !bus_valid && (stall_q == '0);
    stall_d  = stall_q;
    if (bus_valid || !rx_state) stall_d = TO_W'(TIMEOUT - 1);
    else if (stall_q != '0)     stall_d = stall_q - TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= TO_W'(TIMEOUT - 1);
    else       stall_q <= stall_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^(32'(TIMEOUT));
  assign abort          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      write_q <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      write_q <= write_d;
      re_q    <= re_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    write_d   = write_q;
    re_d      = 1'b0;
    addr_done = 1'b0;
    case (state_q)
      IDLE: if (bus_valid) begin
        write_d   = bus_write_en;
        addr_d    = ADDR_WIDTH'(bus_address);
        cnt_d     = CNT_W'(1);
        state_d   = RX_ADDR;
        addr_done = (ADDR_WIDTH == 1);
      end
      RX_ADDR: if (abort) begin
        state_d = IDLE;
      end else if (bus_valid) begin
        addr_d    = ADDR_WIDTH'({addr_q, bus_address});
        cnt_d     = cnt_q + CNT_W'(1);
        addr_done = (cnt_q == CNT_W'(ADDR_WIDTH - 1));
      end
      RX_DATA: if (abort) begin
        state_d = IDLE;
      end else if (bus_valid) begin
        data_d = DATA_WIDTH'({data_q, bus_data});
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = WRITE;
      end
      WRITE: state_d = IDLE;
      READ_WAIT: if (lat_q == '0) begin
        data_d  = out_of_range(addr_q) ? '0 : mem_rdata;
        cnt_d   = '0;
        state_d = TX_DATA;
      end else begin
        lat_d = lat_q - LAT_W'(1);
      end
      TX_DATA: if (bus_ready) begin
        data_d = DATA_WIDTH'({data_q, 1'b0});
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // mem_re is registered so it lines up with the fully assembled address.
    if (addr_done) begin
      cnt_d = '0;
      if (write_d) begin
        state_d = RX_DATA;
      end else begin
        state_d = READ_WAIT;
        lat_d   = LAT_W'(READ_LATENCY);
        re_d    = !out_of_range(addr_d);
      end
    end
  end

  always_comb begin
    slave_ready     = (state_q == IDLE);
    slave_valid_out = (state_q == TX_DATA) && bus_ready;
    slave_data_out  = (state_q == TX_DATA) && data_q[DATA_WIDTH-1];
    mem_we          = (state_q == WRITE) && !out_of_range(addr_q);
    mem_re          = re_q;
    mem_addr        = addr_q;
    mem_wdata       = data_q;
    frame_error     = abort;
  end

endmodule

// File: tb/tb_serial_slave_port.sv
// Scoreboard bench for serial_slave_port: memory strobes and serial read bits are
// popped from expectation queues filled when each frame is driven.
module tb_serial_slave_port;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 2048;
  localparam int RL    = 1;
  localparam int TO    = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bus_address = 1'b0, bus_data = 1'b0, bus_valid = 1'b0;
  logic          bus_write_en = 1'b0, bus_ready = 1'b0;
  logic          slave_ready, slave_data_out, slave_valid_out;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_re, frame_error;

  always #5 clk = ~clk;

  serial_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
                      .READ_LATENCY(RL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus_address(bus_address), .bus_data(bus_data),
    .bus_valid(bus_valid), .bus_write_en(bus_write_en), .bus_ready(bus_ready),
    .slave_ready(slave_ready), .slave_data_out(slave_data_out),
    .slave_valid_out(slave_valid_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .frame_error(frame_error));

  // Memory on the DUT side, latency 1
  logic [DW-1:0] tb_mem [0:4095];
  always @(posedge clk) begin
    if (reset) begin
      tb_mem[12'h010] <= 8'hC3;
      tb_mem[12'hFFF] <= 8'hFF;
    end else if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= tb_mem[mem_addr];
  end

  logic [DW-1:0]    model_mem [0:4095];
  logic [AW+DW-1:0] exp_wr [$];
  logic [AW-1:0]    exp_rd [$];
  logic             exp_bit [$];
  int n_checks = 0, n_fail = 0;
  int n_we = 0, n_re = 0, n_fe = 0;
  int exp_we_total = 0, exp_re_total = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    logic [AW-1:0]    ea;
    logic             eb;
    if (mem_we) begin
      n_we++;
      check("we_expected", 32'(exp_wr.size() > 0), 1);
      if (exp_wr.size() > 0) begin
        e = exp_wr.pop_front();
        check("we_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
        check("we_data", 32'(mem_wdata), 32'(e[DW-1:0]));
      end
    end
    if (mem_re) begin
      n_re++;
      check("re_expected", 32'(exp_rd.size() > 0), 1);
      if (exp_rd.size() > 0) begin
        ea = exp_rd.pop_front();
        check("re_addr", 32'(mem_addr), 32'(ea));
      end
    end
    if (slave_valid_out) begin
      check("bit_expected", 32'(exp_bit.size() > 0), 1);
      if (exp_bit.size() > 0) begin
        eb = exp_bit.pop_front();
        check("tx_bit", 32'(slave_data_out), 32'(eb));
      end
    end
    if (frame_error) n_fe++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !slave_ready; i++) tick();
    check("ready_wait", 32'(slave_ready), 1);
  endtask

  task automatic send_frame(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input int gap_a, input int gap_b, input int gap_len);
    wait_ready();
    for (int i = 0; i < AW; i++) begin
      bus_valid    = 1'b1;
      bus_write_en = (i == 0) ? we : ~we;
      bus_address  = addr[AW-1-i];
      bus_data     = ~addr[AW-1-i];
      tick();
      if (i + 1 == gap_a || i + 1 == gap_b) begin
        bus_valid   = 1'b0;
        bus_address = ~bus_address;
        repeat (gap_len) tick();
      end
    end
    if (we) begin
      for (int i = 0; i < DW; i++) begin
        bus_valid   = 1'b1;
        bus_data    = data[DW-1-i];
        bus_address = ~data[DW-1-i];
        tick();
      end
    end
    bus_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int gap_a, input int gap_b, input int gap_len);
    if (addr < DEPTH) begin
      exp_wr.push_back({addr, data});
      model_mem[addr] = data;
      exp_we_total++;
    end
    send_frame(1'b1, addr, data, gap_a, gap_b, gap_len);
    check("wr_ready_c1", 32'(slave_ready), 0);
    tick();
    check("wr_ready_c2", 32'(slave_ready), 1);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int gap_at, input int gap_len);
    int  bits, first, last, gap_left;
    logic gap_now;
    logic [DW-1:0] d;
    d = (addr < DEPTH) ? model_mem[addr] : '0;
    if (addr < DEPTH) begin
      exp_rd.push_back(addr);
      exp_re_total++;
    end
    for (int i = DW - 1; i >= 0; i--) exp_bit.push_back(d[i]);
    bus_ready = 1'b1;
    send_frame(1'b0, addr, '0, 0, 0, 0);
    bits = 0; first = -1; last = -1; gap_left = gap_len;
    for (int cyc = 0; cyc < 60 && bits < DW; cyc++) begin
      gap_now = (bits == gap_at) && (gap_left > 0);
      bus_ready = !gap_now;
      if (gap_now) gap_left--;
      @(negedge clk);
      if (gap_now) check("gap_valid", 32'(slave_valid_out), 0);
      if (slave_valid_out) begin
        if (first < 0) first = cyc;
        last = cyc;
        bits++;
      end
      tick();
    end
    check("rd_bits", 32'(bits), DW);
    check("rd_span", 32'(last - first + 1), 32'(DW + gap_len));
    check("rd_ready", 32'(slave_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_mem[12'h010] = 8'hC3;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_ready", 32'(slave_ready), 1);
    check("rst_valid", 32'(slave_valid_out), 0);
    check("rst_dout", 32'(slave_data_out), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_re", 32'(mem_re), 0);
    check("rst_ferr", 32'(frame_error), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);

    do_write(12'h0A5, 8'h3C, 0, 0, 0);
    do_read(12'h010, 0, 0);
    do_read(12'h010, 2, 3);
    do_write(12'h0A5, 8'h3C, 3, 10, 2);
    do_read(12'h0A5, 0, 0);

    do_read(12'hFFF, 0, 0);
    do_write(12'hFFF, 8'hA5, 0, 0, 0);
    do_read(12'hFFF, 0, 0);

    // Reset lands with the sixth address bit
    wait_ready();
    for (int i = 0; i < 6; i++) begin
      bus_valid    = 1'b1;
      bus_write_en = 1'b1;
      bus_address  = i[0];
      if (i == 5) reset = 1'b1;
      tick();
    end
    reset     = 1'b0;
    bus_valid = 1'b0;
    check("midrst_ready", 32'(slave_ready), 1);
    check("midrst_ferr", 32'(frame_error), 0);
    repeat (20) tick();
    do_write(12'h123, 8'h5A, 0, 0, 0);
    do_read(12'h123, 0, 0);

`ifdef SERIAL_SLAVE_PORT_TIMEOUT_EN
    begin
      int found;
      wait_ready();
      for (int i = 0; i < 3; i++) begin
        bus_valid    = 1'b1;
        bus_write_en = 1'b1;
        bus_address  = 1'b1;
        tick();
      end
      bus_valid = 1'b0;
      found = -1;
      for (int k = 1; k <= 100 && found < 0; k++) begin
        @(negedge clk);
        if (frame_error) found = k;
        tick();
      end
      check("to_cycle", 32'(found), TO);
      check("to_ready", 32'(slave_ready), 1);
      check("to_pulse", 32'(frame_error), 0);
      repeat (5) tick();
      check("to_fe_count", 32'(n_fe), 1);
    end
`else
    check("fe_count", 32'(n_fe), 0);
`endif

    repeat (5) tick();
    check("wr_queue_left", 32'(exp_wr.size()), 0);
    check("rd_queue_left", 32'(exp_rd.size()), 0);
    check("bit_queue_left", 32'(exp_bit.size()), 0);
    check("we_count", 32'(n_we), 32'(exp_we_total));
    check("re_count", 32'(n_re), 32'(exp_re_total));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_slave_port.md
Name: serial_slave_port

Overview:
- Slave-side endpoint of the bit-serial bus, directly downstream of the arbiter's sN_* outputs.
- Deserialises address and write data from the arbiter, then performs one write or read on a local synchronous memory port.
- On a read, serialises the read data back toward the master.
- Drives slave_ready, which the arbiter uses for slave selection and split-transaction timing.

Parameters:
ADDR_WIDTH, 12, serial address bits per frame; also the width of mem_addr.
DATA_WIDTH, 8, data bits per frame; also the width of mem_wdata and mem_rdata.
MEM_DEPTH, 4096, number of valid locations; addresses >= MEM_DEPTH are out of range.
READ_LATENCY, 1, cycles from mem_re to valid mem_rdata (1..4).
TIMEOUT, 64, stall-cycle limit; used only with the optional feature.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
bus_address  in  1  serial address bit from arbiter, MSB first
bus_data  in  1  serial write-data bit from arbiter, MSB first
bus_valid  in  1  qualifies bus_address/bus_data for the current cycle
bus_write_en  in  1  1=write, 0=read; sampled on the first valid cycle of a frame
bus_ready  in  1  arbiter permits this slave to drive return data
slave_ready  out  1  1 only in IDLE
slave_data_out  out  1  serial read-data bit, MSB first
slave_valid_out  out  1  qualifies slave_data_out
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_we  out  1  one-cycle write strobe
mem_re  out  1  one-cycle read strobe
mem_rdata  in  DATA_WIDTH  memory read data
frame_error  out  1  one-cycle pulse on an aborted frame

Behaviour:
- Reset (synchronous) requirements:
  - All registers clear and state = IDLE.
  - Outputs: slave_ready=1; slave_data_out, slave_valid_out, mem_we, mem_re, frame_error = 0; mem_addr and mem_wdata = 0.
  - Reset mid-frame aborts the frame with no memory strobe and no frame_error.
- States: IDLE, RX_ADDR, RX_DATA, WRITE, READ_WAIT, TX_DATA.
- IDLE:
  - slave_ready=1.
  - A cycle with bus_valid=1 latches bus_write_en, shifts in the first address bit, sets bit count to 1 and moves to RX_ADDR (or directly past RX_ADDR if ADDR_WIDTH==1).
  - slave_ready drops the cycle after that first valid.
- RX_ADDR:
  - Each bus_valid=1 cycle shifts bus_address into the address register (shift left, LSB in) and increments the count.
  - bus_valid=0 stalls; no shift, count held.
  - After ADDR_WIDTH bits: write goes to RX_DATA; read goes to READ_WAIT with mem_re pulsed in the transition cycle.
  - bus_ready is ignored during receive.
- RX_DATA:
  - Same shifting rule on bus_data.
  - After DATA_WIDTH bits, go to WRITE.
- WRITE:
  - Single cycle. mem_we=1 with mem_addr/mem_wdata stable, then IDLE.
  - Write-to-ready latency: slave_ready=1 two cycles after the last data bit.
- READ_WAIT:
  - Counts READ_LATENCY cycles after mem_re, then captures mem_rdata into the shift register and goes to TX_DATA.
- TX_DATA:
  - When bus_ready=1: slave_valid_out=1, slave_data_out=shift MSB; the register shifts, count increments.
  - When bus_ready=0: slave_valid_out=0, bit held, no shift.
  - After DATA_WIDTH valid bits, go to IDLE.
  - Bits are contiguous whenever bus_ready stays high.
- Out-of-range address (>= MEM_DEPTH):
  - Write: frame completes, mem_we suppressed.
  - Read: mem_re suppressed; all-zero data is transmitted with normal timing.
- bus_valid=1 in any non-RX state is ignored. A new frame is accepted only in IDLE.
- frame_error is 0 unless the optional feature is compiled in.

Optional Feature:
SERIAL_SLAVE_PORT_TIMEOUT_EN
- Defined:
  - A stall counter runs in RX_ADDR/RX_DATA. It clears on every bus_valid=1 cycle and increments otherwise.
  - Reaching TIMEOUT consecutive stall cycles aborts the frame: one-cycle frame_error pulse, no memory strobe, return to IDLE the next cycle.
  - TX_DATA is not subject to timeout.
- Undefined: no stall counter; frame_error tied to 0; RX waits indefinitely.

Test Plan:
- Write 0x0A5 <- 0x3C, bus_valid continuous for 12+8 cycles -> one mem_we pulse with mem_addr=0x0A5, mem_wdata=0x3C; slave_ready=1 two cycles after the last bit.
- Read 0x010, mem_rdata=0xC3, READ_LATENCY=1, bus_ready=1 -> mem_re one pulse, then slave_data_out bits 1,1,0,0,0,0,1,1 on 8 contiguous cycles with slave_valid_out=1.
- Same read with bus_ready low for 3 cycles after bit 2 -> slave_valid_out=0 for those 3 cycles; remaining bits resume unchanged; total 8 valid bits.
- Write with bus_valid gaps (2-cycle stalls after address bits 3 and 10) -> identical result to the continuous write; no extra strobes.
- Read 0xFFF with MEM_DEPTH=2048 -> no mem_re; eight 0 bits transmitted. Write to 0xFFF -> no mem_we.
- Reset asserted at address bit 6 -> slave_ready=1 next cycle, no strobes. With SERIAL_SLAVE_PORT_TIMEOUT_EN and TIMEOUT=64: 64 stall cycles -> frame_error single pulse, then IDLE.
